skin_segmenter: RTL and testbench
=================================

// Module: skin_segmenter
// PURPOSE
//  Parametrised, streaming hand segmenter; next generation of the 1-bit skin/background decider.
//  Sits between the YCbCr converter and the morphology/feature stage.
//  Classifies each valid pixel by YCbCr skin window or by |luma - stored background luma|.
//  Adds valid/SOF framing, on-demand background capture, frame-length checking and a fixed 2-cycle latency.
// PARAMETERS
//  PIX_W        8      channel width (luma, cb, cr)
//  FRAME_PIXELS 19200  pixels per frame (160x120); background RAM depth
//  ADDR_W       15     pixel index width; requires 2**ADDR_W >= FRAME_PIXELS
//  DIFF_TH      20     background-difference threshold, luma LSBs
//  Y_MIN        80     skin window: luma > Y_MIN
//  CB_MIN/CB_MAX 125/180  skin window: CB_MIN < cb < CB_MAX
//  CR_MIN/CR_MAX 190/225  skin window: CR_MIN < cr < CR_MAX
//  ADAPT_SH     3      background adaptation shift; used only with SEG_BG_ADAPT_EN
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous reset, active high
//  in_valid     in   1      pixel qualifier
//  in_sof       in   1      first pixel of frame; meaningful only with in_valid
//  luma_ch      in   PIX_W  Y sample
//  cb_ch        in   PIX_W  Cb sample
//  cr_ch        in   PIX_W  Cr sample
//  bg_mode      in   1      0 = skin window, 1 = background difference
//  capture_req  in   1      one-cycle pulse: capture the next full frame as background
//  out_valid    out  1      in_valid delayed by 2 cycles
//  object_image out  1      1 = hand/object pixel; qualified by out_valid
//  bg_ready     out  1      background RAM holds one complete frame
//  frame_err    out  1      one-cycle pulse on a short or long frame
// BEHAVIOUR
//  Reset: out_valid=0, object_image=0, bg_ready=0, frame_err=0, state=BG_EMPTY, index=0, armed=0.
//    RAM contents are not reset.
//  Pipeline, no backpressure, fixed latency of 2 cycles for both modes:
//    S1 registers the inputs and issues a synchronous RAM read at the pixel index.
//    S2 computes the decision and registers the outputs.
//  Pixel index: in_valid&in_sof loads 0; each later in_valid increments it.
//  Long frame (index would exceed FRAME_PIXELS-1):
//    index holds; extra pixels output object_image=0; frame_err pulses once per frame.
//  Short frame (in_sof with index != FRAME_PIXELS-1 after an earlier SOF): frame_err pulses once.
//  bg_mode is sampled only on an SOF pixel and held for the whole frame.
//  Skin decision: (luma>Y_MIN)&&(cb>CB_MIN)&&(cb<CB_MAX)&&(cr>CR_MIN)&&(cr<CR_MAX).
//  Difference decision: absdiff = |luma - bg|, computed unsigned at PIX_W+1 bits;
//    object = (absdiff > DIFF_TH).
//  FSM:
//    BG_EMPTY/BG_READY + (capture_req | armed) + SOF pixel -> BG_CAPTURE.
//    capture_req outside an SOF cycle sets armed; armed clears on entry to BG_CAPTURE.
//    BG_CAPTURE: writes luma to RAM[index]; object_image=0 in both modes.
//      Last pixel (index FRAME_PIXELS-1) written -> BG_READY, bg_ready=1 from the next cycle.
//      Early SOF (short capture): frame_err pulses; capture restarts at index 0; bg_ready=0.
//      capture_req is ignored.
//    bg_ready drops to 0 on entry to BG_CAPTURE.
//  bg_mode=1 while bg_ready=0: object_image=0; out_valid still follows in_valid.
//  Reset mid-frame: everything above returns to its reset value. The next frame must start with SOF;
//    pixels before that SOF are passed with object_image=0.
// CONFIGURATION
//  SEG_BG_ADAPT_EN defined:
//    In BG_READY with bg_mode=1, pixels with object=0 write back in S2:
//      bg <= bg + ((luma - bg) >>> ADAPT_SH)   (signed, PIX_W+1 bits, never wraps)
//    Same-address read/write collision cannot occur for FRAME_PIXELS>=3.
//  SEG_BG_ADAPT_EN undefined:
//    The RAM is written only in BG_CAPTURE; the ADAPT_SH logic is absent.
// TESTING
//  Skin mode, Y=100/Cb=150/Cr=200 -> object_image=1 two cycles later; Cr=190 -> 0 (strict bounds).
//  capture_req, then one 19200-pixel frame of Y=50:
//    object_image=0 throughout; bg_ready=1 after the last pixel.
//  Then bg_mode=1: Y=71 -> 1; Y=70 -> 0; Y=29 -> 1; Y=30 -> 0 (DIFF_TH=20, bidirectional).
//  SOF after 100 pixels during capture -> frame_err pulse; capture restarts; bg_ready stays 0.
//  Long frame of 19201 pixels -> one frame_err pulse; pixel 19201 gives object_image=0.
//  SEG_BG_ADAPT_EN, bg=50, Y=60 repeated over frames -> bg becomes 51, then 52;
//    rst asserted mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/skin_segmenter_if.sv
`default_nettype none
// ============================================================================
//  Module      : skin_segmenter_if
//  Description : Pixel stream bundle between a YCbCr source and the
//                skin_segmenter.
//                master : pixel source / result sink
//                slave  : skin_segmenter
//                Inputs to the segmenter: in_valid, in_sof, luma_ch, cb_ch,
//                cr_ch, bg_mode, capture_req.
//                Outputs from the segmenter: out_valid, object_image,
//                bg_ready, frame_err.
//  Revision    : 1.0  initial release
// ============================================================================
interface skin_segmenter_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] luma_ch;
    logic [PIX_W-1:0] cb_ch;
    logic [PIX_W-1:0] cr_ch;
    logic             bg_mode;
    logic             capture_req;
    logic             out_valid;
    logic             object_image;
    logic             bg_ready;
    logic             frame_err;

    modport master (
        output in_valid, in_sof, luma_ch, cb_ch, cr_ch, bg_mode, capture_req,
        input  out_valid, object_image, bg_ready, frame_err
    );

    modport slave (
        input  in_valid, in_sof, luma_ch, cb_ch, cr_ch, bg_mode, capture_req,
        output out_valid, object_image, bg_ready, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/skin_segmenter.sv
`default_nettype none
// ============================================================================
//  Module      : skin_segmenter
//  Description : Streaming 1-bit hand/object segmenter. Each valid pixel is
//                classified either by a strict YCbCr skin window or by the
//                absolute luma difference to a stored background frame.
//                Fixed 2-cycle latency, no backpressure, SOF framing with
//                short/long frame detection, on-demand background capture.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous reset, active high
//                bus  - skin_segmenter_if.slave pixel stream bundle
//  Options     : SEG_BG_ADAPT_EN - when defined, background pixels that are
//                classified as background in difference mode slowly track
//                the live luma (step = (luma - bg) >>> ADAPT_SH).
//  Revision    : 1.0  initial release
// ============================================================================
module skin_segmenter #(
    parameter int PIX_W        = 8,
    parameter int FRAME_PIXELS = 19200,
    parameter int ADDR_W       = 15,
    parameter int DIFF_TH      = 20,
    parameter int Y_MIN        = 80,
    parameter int CB_MIN       = 125,
    parameter int CB_MAX       = 180,
    parameter int CR_MIN       = 190,
    parameter int CR_MAX       = 225,
    parameter int ADAPT_SH     = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    skin_segmenter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [PIX_W-1:0]  c_Y_MIN   = PIX_W'(Y_MIN);
    localparam logic [PIX_W-1:0]  c_CB_MIN  = PIX_W'(CB_MIN);
    localparam logic [PIX_W-1:0]  c_CB_MAX  = PIX_W'(CB_MAX);
    localparam logic [PIX_W-1:0]  c_CR_MIN  = PIX_W'(CR_MIN);
    localparam logic [PIX_W-1:0]  c_CR_MAX  = PIX_W'(CR_MAX);
    localparam logic [PIX_W:0]    c_DIFF_TH = (PIX_W+1)'(DIFF_TH);

    generate
        if ((2 ** ADDR_W) < FRAME_PIXELS || FRAME_PIXELS < 3 || ADAPT_SH < 0) begin : g_bad_cfg
            $error("skin_segmenter: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        BG_EMPTY   = 2'd0,
        BG_CAPTURE = 2'd1,
        BG_READY   = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;
    logic   r_armed, w_armed_nxt;

    // ------------------------------------------------------------------
    // Frame tracking: r_idx is the index of the most recent valid pixel.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_idx, w_idx;
    logic              r_in_frame, r_long_seen, r_mode;
    logic              w_pix, w_sof, w_framed, w_over, w_short, w_long;
    logic              w_mode, w_cap_we, w_zero;

    always_comb begin
        w_pix    = bus.in_valid;
        w_sof    = bus.in_valid & bus.in_sof;
        // a pixel only has a meaningful index once an SOF has been seen
        w_framed = w_sof | r_in_frame;
        w_over   = w_pix & ~w_sof & r_in_frame & (r_idx == c_LAST);
        w_short  = w_sof & r_in_frame & (r_idx != c_LAST);
        w_long   = w_over & ~r_long_seen;
        w_mode   = w_sof ? bus.bg_mode : r_mode;
        if (w_sof) begin
            w_idx = '0;
        end else if (w_pix & r_in_frame & ~w_over) begin
            w_idx = r_idx + 1'b1;
        end else begin
            w_idx = r_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_in_frame  <= 1'b0;
            r_long_seen <= 1'b0;
            r_mode      <= 1'b0;
        end else if (w_pix) begin
            r_idx       <= w_idx;
            r_in_frame  <= w_framed;
            r_long_seen <= w_sof ? 1'b0 : (r_long_seen | w_over);
            r_mode      <= w_mode;
        end
    end

    // ------------------------------------------------------------------
    // Background FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BG_EMPTY;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        w_cap_we    = 1'b0;
        case (r_state)
            BG_CAPTURE: begin
                // an early SOF simply writes index 0 again: capture restarts
                if (w_pix & w_framed & ~w_over) begin
                    w_cap_we = 1'b1;
                    if (w_idx == c_LAST) begin
                        w_state_nxt = BG_READY;
                    end
                end
            end
            BG_EMPTY, BG_READY: begin
                if (w_sof & (bus.capture_req | r_armed)) begin
                    w_state_nxt = BG_CAPTURE;
                    w_armed_nxt = 1'b0;
                    w_cap_we    = 1'b1;
                end else if (bus.capture_req) begin
                    w_armed_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = BG_EMPTY;
            end
        endcase
        // pixels that can never be an object regardless of classification
        w_zero = ~w_framed | w_over | w_cap_we | (w_mode & (r_state != BG_READY));
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic             r_s1_valid, r_s1_mode, r_s1_zero, r_s1_err;
    logic [PIX_W-1:0] r_s1_luma, r_s1_cb, r_s1_cr;
`ifdef SEG_BG_ADAPT_EN
    logic [ADDR_W-1:0] r_s1_idx;
    logic              r_s1_adapt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_luma  <= '0;
            r_s1_cb    <= '0;
            r_s1_cr    <= '0;
`ifdef SEG_BG_ADAPT_EN
            r_s1_idx   <= '0;
            r_s1_adapt <= 1'b0;
`endif
        end else begin
            r_s1_valid <= w_pix;
            r_s1_mode  <= w_mode;
            r_s1_zero  <= w_zero;
            r_s1_err   <= w_short | w_long;
            r_s1_luma  <= bus.luma_ch;
            r_s1_cb    <= bus.cb_ch;
            r_s1_cr    <= bus.cr_ch;
`ifdef SEG_BG_ADAPT_EN
            r_s1_idx   <= w_idx;
            r_s1_adapt <= w_pix & w_mode & ~w_zero;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Background RAM: single write port, registered read (not reset)
    // ------------------------------------------------------------------
    logic [PIX_W-1:0]  r_ram [FRAME_PIXELS];
    logic [PIX_W-1:0]  r_bg;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [PIX_W-1:0]  w_wdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ram[w_waddr] <= w_wdata;
        end
        r_bg <= r_ram[w_idx];
    end

    // ------------------------------------------------------------------
    // Stage 2 decision
    // ------------------------------------------------------------------
    logic signed [PIX_W:0] w_diff;
    logic        [PIX_W:0] w_abs;
    logic                  w_skin, w_bgobj, w_obj;

    always_comb begin
        w_diff  = $signed({1'b0, r_s1_luma}) - $signed({1'b0, r_bg});
        w_abs   = w_diff[PIX_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
        w_bgobj = (w_abs > c_DIFF_TH);
        w_skin  = (r_s1_luma > c_Y_MIN) &&
                  (r_s1_cb > c_CB_MIN) && (r_s1_cb < c_CB_MAX) &&
                  (r_s1_cr > c_CR_MIN) && (r_s1_cr < c_CR_MAX);
        w_obj   = r_s1_valid & ~r_s1_zero & (r_s1_mode ? w_bgobj : w_skin);
    end

`ifdef SEG_BG_ADAPT_EN
    // floor-shifted step always lands between bg and luma, so no wrap
    logic signed [PIX_W:0] w_step, w_sum;
    always_comb begin
        w_step = w_diff >>> ADAPT_SH;
        w_sum  = $signed({1'b0, r_bg}) + w_step;
    end
`endif

    always_comb begin
        w_we    = w_cap_we;
        w_waddr = w_idx;
        w_wdata = bus.luma_ch;
`ifdef SEG_BG_ADAPT_EN
        // capture wins a same-cycle conflict: the adapted entry belongs to a
        // frame that is being replaced anyway
        if (!w_cap_we && r_s1_valid && r_s1_adapt && !w_bgobj) begin
            w_we    = 1'b1;
            w_waddr = r_s1_idx;
            w_wdata = w_sum[PIX_W-1:0];
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic r_out_valid, r_obj, r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_obj       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_obj       <= w_obj;
            r_err       <= r_s1_err;
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.object_image = r_obj;
    assign bus.frame_err    = r_err;
    assign bus.bg_ready     = (r_state == BG_READY);

endmodule
`default_nettype wire

// File: tb/tb_skin_segmenter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_skin_segmenter
//  Description : Directed self-checking bench for skin_segmenter using a
//                16-pixel frame. Each step drives one input cycle and checks
//                the outputs belonging to the pixel of the previous step
//                (two cycles of latency relative to its presentation).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_skin_segmenter;
    localparam int PIX_W        = 8;
    localparam int FRAME_PIXELS = 16;
    localparam int ADDR_W       = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    skin_segmenter_if #(.PIX_W(PIX_W)) seg_if ();

    skin_segmenter #(
        .PIX_W(PIX_W), .FRAME_PIXELS(FRAME_PIXELS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(seg_if)
    );

    int    errors = 0;
    int    checks = 0;
    int    stepn  = 0;
    string tag    = "init";
    logic  pv = 1'b0, po = 1'b0, pe = 1'b0;

    task automatic chk(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s step %0d: observed %b expected %b", tag, name, stepn, obs, exp);
        end
    endtask

    // drive one cycle, then check the previous step's pixel
    task automatic step(input logic v, input logic s, input logic [7:0] y,
                        input logic [7:0] cb, input logic [7:0] cr,
                        input logic eo, input logic ee);
        seg_if.in_valid = v;
        seg_if.in_sof   = s;
        seg_if.luma_ch  = y;
        seg_if.cb_ch    = cb;
        seg_if.cr_ch    = cr;
        @(posedge clk);
        #1;
        stepn++;
        seg_if.capture_req = 1'b0;
        chk("out_valid",    seg_if.out_valid,    pv);
        chk("object_image", seg_if.object_image, po);
        chk("frame_err",    seg_if.frame_err,    pe);
        pv = v;
        po = eo & v;
        pe = ee;
    endtask

    task automatic run(input int n, input logic [7:0] y, input logic [7:0] cb,
                       input logic [7:0] cr, input logic eo);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, y, cb, cr, eo, 1'b0);
    endtask

    initial begin
        rst                = 1'b1;
        seg_if.in_valid    = 1'b0;
        seg_if.in_sof      = 1'b0;
        seg_if.luma_ch     = '0;
        seg_if.cb_ch       = '0;
        seg_if.cr_ch       = '0;
        seg_if.bg_mode     = 1'b0;
        seg_if.capture_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tag = "reset";
        chk("out_valid",    seg_if.out_valid,    1'b0);
        chk("object_image", seg_if.object_image, 1'b0);
        chk("bg_ready",     seg_if.bg_ready,     1'b0);
        chk("frame_err",    seg_if.frame_err,    1'b0);
        rst = 1'b0;

        // skin window, strict bounds, one bubble
        tag = "skin";
        seg_if.bg_mode = 1'b0;
        step(1, 1, 100, 150, 200, 1, 0);
        step(1, 0, 100, 150, 190, 0, 0);
        step(1, 0, 100, 150, 225, 0, 0);
        step(1, 0, 100, 125, 200, 0, 0);
        step(0, 0, 100, 150, 200, 0, 0);
        step(1, 0,  80, 150, 200, 0, 0);
        step(1, 0,  81, 179, 224, 1, 0);
        run(10, 0, 0, 0, 0);

        // armed capture of a Y=50 frame
        tag = "capture";
        seg_if.capture_req = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 50, 150, 200, 0, 0);
        chk("bg_ready_during", seg_if.bg_ready, 1'b0);
        run(14, 50, 150, 200, 0);
        chk("bg_ready_before_last", seg_if.bg_ready, 1'b0);
        run(1, 50, 150, 200, 0);
        chk("bg_ready_after_last", seg_if.bg_ready, 1'b1);

        // difference mode, mid-frame bg_mode change ignored
        tag = "diff";
        seg_if.bg_mode = 1'b1;
        step(1, 1, 71, 0, 0, 1, 0);
        seg_if.bg_mode = 1'b0;
        step(1, 0, 70, 0, 0, 0, 0);
        step(1, 0, 29, 0, 0, 1, 0);
        step(1, 0, 30, 0, 0, 0, 0);
        step(1, 0, 90, 100, 100, 1, 0);
        run(11, 50, 0, 0, 0);

        // capture restarted by an early SOF
        tag = "short_capture";
        seg_if.capture_req = 1'b1;
        step(1, 1, 50, 0, 0, 0, 0);
        chk("bg_ready_drop", seg_if.bg_ready, 1'b0);
        run(4, 50, 0, 0, 0);
        step(1, 1, 50, 0, 0, 0, 1);
        chk("bg_ready_restart", seg_if.bg_ready, 1'b0);
        run(15, 50, 0, 0, 0);
        chk("bg_ready_recaptured", seg_if.bg_ready, 1'b1);

        // long frame: one pulse, extra pixels forced to 0
        tag = "long";
        seg_if.bg_mode = 1'b1;
        step(1, 1, 50, 0, 0, 0, 0);
        run(15, 50, 0, 0, 0);
        step(1, 0, 200, 0, 0, 0, 1);
        step(1, 0, 200, 0, 0, 0, 0);

        // restart after long frame, then a short frame
        tag = "short";
        step(1, 1, 200, 0, 0, 1, 0);
        run(2, 50, 0, 0, 0);
        step(1, 1, 50, 0, 0, 0, 1);
        run(15, 50, 0, 0, 0);

`ifdef SEG_BG_ADAPT_EN
        // bg 50 -> 51 -> 52 through two Y=60 frames
        tag = "adapt";
        step(1, 1, 60, 0, 0, 0, 0);
        run(15, 60, 0, 0, 0);
        step(1, 1, 60, 0, 0, 0, 0);
        run(15, 60, 0, 0, 0);
        step(1, 1, 73, 0, 0, 1, 0);
        step(1, 0, 72, 0, 0, 0, 0);
        step(1, 0, 31, 0, 0, 1, 0);
        step(1, 0, 32, 0, 0, 0, 0);
        run(12, 52, 0, 0, 0);
`endif

        // asynchronous reset in the middle of a frame
        tag = "async_rst";
        seg_if.bg_mode = 1'b1;
        step(1, 1, 200, 0, 0, 1, 0);
        step(1, 0, 200, 0, 0, 1, 0);
        chk("obj_before_rst", seg_if.object_image, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("out_valid_rst",    seg_if.out_valid,    1'b0);
        chk("object_image_rst", seg_if.object_image, 1'b0);
        chk("bg_ready_rst",     seg_if.bg_ready,     1'b0);
        chk("frame_err_rst",    seg_if.frame_err,    1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pv = 1'b0;
        po = 1'b0;
        pe = 1'b0;

        // pixels before the first SOF after reset are never objects
        tag = "post_rst";
        seg_if.bg_mode = 1'b0;
        step(1, 0, 100, 150, 200, 0, 0);
        step(1, 0, 100, 150, 200, 0, 0);
        step(1, 1, 100, 150, 200, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
